// File: rtl/score_bcd_conv_pkg.sv
// ============================================================================
//  Module   : score_bcd_conv_pkg
//  Purpose  : Shared game constants for the score display path. It holds the
//             blank digit code, the default score width, the converter state
//             encoding and the leading-zero blanking helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_bcd_conv_pkg;

  // Default width of the binary score (0..1023).
  localparam int SCORE_W_DEFAULT = 10;

  // Digit code that the seven-segment decoder renders as an unlit digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Converter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Replace zero digits above the most significant non-zero digit with
  // BCD_BLANK. The ones digit is never blanked, so zero still shows "0".
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
    logic [15:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'h0)) begin
        res[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
// ============================================================================
//  Module   : bcd_nibble_adj
//  Purpose  : Double-dabble correction for one BCD digit. A digit of 5 or
//             more gets 3 added so that the following left shift carries
//             correctly into the next decimal digit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_nibble_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Valid BCD input is at most 9, so the sum is at most 12 and fits in 4 bits.
  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

`default_nettype wire

// File: rtl/score_bcd_conv.sv
// ============================================================================
//  Module   : score_bcd_conv
//  Purpose  : Iterative binary-to-BCD converter for the score display. It
//             processes one input bit per clock using shift-add-3. The four
//             digit outputs are registered and change only on a Done pulse.
//             They can optionally blank leading zeros.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_bcd_conv
  import score_bcd_conv_pkg::*;
#(
  // Binary score width. The 16-bit accumulator holds up to 9999, so W <= 13.
  parameter int W          = SCORE_W_DEFAULT,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [W-1:0] Bin,
  output logic         Busy,
  output logic         Done,
  output logic [3:0]   Ones,
  output logic [3:0]   Tens,
  output logic [3:0]   Hundreds,
  output logic [3:0]   Thousands
);

  // Counter value on the cycle that performs the final (W-th) shift.
  localparam logic [3:0]  LAST_CNT   = 4'(W - 1);
  // Digit register contents after reset: "0" with blanked upper digits,
  // or plain 0000 when blanking is off.
  localparam logic [15:0] RST_DIGITS = LEAD_BLANK ? {BCD_BLANK, BCD_BLANK, BCD_BLANK, 4'h0}
                                                  : 16'h0000;

  conv_state_t    state_q;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   sr_d;
  logic [15:0]    acc_q;
  logic [15:0]    acc_d;
  logic [15:0]    w_adj;
  logic [15:0]    w_digits;
  logic [3:0]     cnt_q;
  logic [15:0]    digits_q;
  logic           busy_q;
  logic           done_q;

  // Apply the add-3 correction to every accumulator digit before the shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      bcd_nibble_adj u_adj (
        .nib_i (acc_q[4*gi +: 4]),
        .nib_o (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Shift the corrected accumulator and the remaining binary bits together.
  // The MSB of the shift register moves into the accumulator LSB.
  assign {acc_d, sr_d} = {w_adj, sr_q} << 1;

  // Display form of the finished accumulator.
  assign w_digits = LEAD_BLANK ? blank_leading(acc_q) : acc_q;

  // Conversion FSM with its registered status and digit outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= RST_DIGITS;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            sr_q    <= Bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          digits_q <= w_digits;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Ones      = digits_q[3:0];
  assign Tens      = digits_q[7:4];
  assign Hundreds  = digits_q[11:8];
  assign Thousands = digits_q[15:12];

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_conv.sv
// ============================================================================
//  Module   : tb_score_bcd_conv
//  Purpose  : Self-checking bench for score_bcd_conv. It runs one instance
//             with leading-zero blanking and one without. Both instances
//             share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_bcd_conv;

  logic       Clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       Start   = 1'b0;
  logic [9:0] Bin     = 10'd0;
  logic       rst_smp = 1'b1;

  logic       Busy1, Done1, Busy0, Done0;
  logic [3:0] O1, T1, H1, K1, O0, T0, H0, K0;

  int total = 0;
  int bad   = 0;

  logic [15:0] q1[$];
  logic [15:0] q0[$];
  logic [15:0] h1 = 16'hFFF0;
  logic [15:0] h0 = 16'h0000;

  score_bcd_conv #(.W(10), .LEAD_BLANK(1'b1)) dut1 (
    .Clk(Clk), .reset(reset), .Start(Start), .Bin(Bin),
    .Busy(Busy1), .Done(Done1),
    .Ones(O1), .Tens(T1), .Hundreds(H1), .Thousands(K1)
  );

  score_bcd_conv #(.W(10), .LEAD_BLANK(1'b0)) dut0 (
    .Clk(Clk), .reset(reset), .Start(Start), .Bin(Bin),
    .Busy(Busy0), .Done(Done0),
    .Ones(O0), .Tens(T0), .Hundreds(H0), .Thousands(K0)
  );

  always #5 Clk = ~Clk;

  // Reset as the DUT saw it on the last rising edge.
  always @(posedge Clk) rst_smp <= reset;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by division, optional leading blank.
  function automatic logic [15:0] model(input int v, input bit lb);
    int          d[4];
    logic [15:0] r;
    bit          lead;
    r    = 16'h0000;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 1000) % 10;
    lead = lb;
    for (int i = 3; i >= 0; i--) begin
      if (lead && (i > 0) && (d[i] == 0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        r[4*i +: 4] = 4'(d[i]);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic push(input int v);
    q1.push_back(model(v, 1'b1));
    q0.push_back(model(v, 1'b0));
  endtask

  // Scoreboard: digits must match on Done, stay frozen otherwise,
  // and show reset values while reset is applied.
  always @(negedge Clk) begin
    if (rst_smp) begin
      q1.delete();
      q0.delete();
      h1 = 16'hFFF0;
      h0 = 16'h0000;
      chk("rst_digits_blank", {K1, H1, T1, O1}, h1);
      chk("rst_digits_plain", {K0, H0, T0, O0}, h0);
    end else begin
      if (Done1) begin
        if (q1.size() == 0) chk("unexpected_done_blank", 16'(Done1), 16'h0);
        else begin
          h1 = q1.pop_front();
          chk("digits_blank", {K1, H1, T1, O1}, h1);
        end
      end else chk("hold_blank", {K1, H1, T1, O1}, h1);
      if (Done0) begin
        if (q0.size() == 0) chk("unexpected_done_plain", 16'(Done0), 16'h0);
        else begin
          h0 = q0.pop_front();
          chk("digits_plain", {K0, H0, T0, O0}, h0);
        end
      end else chk("hold_plain", {K0, H0, T0, O0}, h0);
    end
  end

  // Called just after the accepting edge. Checks Busy/Done over the
  // 12 cycles that follow it and returns at the Done cycle.
  // pulse_k >= 0 raises Start (Bin=7) for one cycle at that point.
  task automatic watch(input int pulse_k);
    for (int k = 0; k < 12; k++) begin
      if (pulse_k >= 0) begin
        if (k == pulse_k) begin
          Start = 1'b1;
          Bin   = 10'd7;
        end else Start = 1'b0;
      end
      @(negedge Clk);
      chk("busy", 16'(Busy1), (k < 11) ? 16'd1 : 16'd0);
      chk("done", 16'(Done1), (k == 11) ? 16'd1 : 16'd0);
      chk("busy_done_plain", {14'b0, Busy0, Done0},
          {14'b0, (k < 11) ? 1'b1 : 1'b0, (k == 11) ? 1'b1 : 1'b0});
      if (k < 11) begin
        @(posedge Clk);
        #1;
      end
    end
  endtask

  task automatic conv(input int v, input int pulse_k);
    Start = 1'b1;
    Bin   = 10'(v);
    push(v);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Bin   = 10'($urandom_range(0, 1023));
    watch(pulse_k);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst_busy_done", {14'b0, Busy1, Done1}, 16'h0);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    @(posedge Clk);
    #1;

    // Basic conversions, including Start ignored mid-conversion
    conv(0, -1);
    conv(999, -1);
    conv(1023, -1);
    conv(100, -1);
    conv(300, 4);
    repeat (13) begin
      @(negedge Clk);
      chk("no_extra_done", 16'(Done1), 16'h0);
      @(posedge Clk);
      #1;
    end

    // Reset at edge 6 of a conversion aborts it
    Start = 1'b1;
    Bin   = 10'd512;
    push(512);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    reset = 1'b1;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge Clk);
      chk("abort_busy_done", {14'b0, Busy1, Done1}, 16'h0);
      @(posedge Clk);
      #1;
    end
    conv(512, -1);

    // Start held high: back-to-back conversions of 41, 42, 43
    Start = 1'b1;
    Bin   = 10'd41;
    push(41);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      if (i < 2) begin
        Bin = 10'(42 + i);
        push(42 + i);
      end else begin
        Start = 1'b0;
        Bin   = 10'd0;
      end
      watch(-1);
    end
    @(posedge Clk);
    #1;

    // Full input range
    for (int v = 0; v < 1024; v++) conv(v, -1);

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_empty_blank", 16'(q1.size()), 16'h0);
    chk("queue_empty_plain", 16'(q0.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
